// File: rtl/adder_pkg.sv
// Shared types for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Value of the SUB input that selects subtraction.
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_slice.sv
// DIGIT-bit combinational ripple slice; also exports the carry into its top bit
// so the caller can derive signed overflow on the most significant digit.
module add_slice #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             CIN,
  output logic [DIGIT-1:0] S,
  output logic             COUT,
  output logic             MSB_CIN
);

  localparam int unsigned SW = DIGIT + 1;

  logic [SW-1:0] sum;

  always_comb begin
    sum     = SW'(A) + SW'(B) + SW'(CIN);
    S       = sum[DIGIT-1:0];
    COUT    = sum[DIGIT];
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
    MSB_CIN = A[DIGIT-1] ^ B[DIGIT-1] ^ sum[DIGIT-1];
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock
// through one shared slice, with valid/ready handshakes on both sides.
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] slice_a, slice_b, slice_s;
  logic             slice_cout, slice_msb_cin;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (IN_VALID) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      IDLE:    IN_READY  = 1'b1;
      DONE:    OUT_VALID = 1'b1;
      default: ;
    endcase
  end

  // Select the current digit of each operand for the shared slice.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        slice_a = a_q[k*DIGIT +: DIGIT];
        slice_b = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  add_slice #(.DIGIT(DIGIT)) u_slice (
    .A       (slice_a),
    .B       (slice_b),
    .CIN     (carry_q),
    .S       (slice_s),
    .COUT    (slice_cout),
    .MSB_CIN (slice_msb_cin)
  );

  // Datapath: operand capture in IDLE, one digit per clock in RUN.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = (SUB == OP_SUB) ? ~B : B;
          carry_d = (SUB == OP_SUB) ? 1'b1 : CIN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) s_d[k*DIGIT +: DIGIT] = slice_s;
        end
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d = slice_cout;
          ovf_d  = slice_msb_cin ^ slice_cout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT = 2, 1, 8) share stimulus and are
// checked every cycle against an arithmetic reference model with per-instance queues.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a_in, b_in;
  logic       cin_in, sub_in;

  logic       in_ready  [3];
  logic       out_valid [3];
  logic [7:0] s_out     [3];
  logic       cout_out  [3];
  logic       ovf_out   [3];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit b2b = 1'b0;

  logic [9:0] expq [3][$];
  logic [9:0] last_res [3];
  logic       prev_ov  [3];
  int         acc_cyc  [3];
  int         prev_acc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready[0]),
    .A(a_in), .B(b_in), .CIN(cin_in), .SUB(sub_in),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready),
    .S(s_out[0]), .COUT(cout_out[0]), .OVF(ovf_out[0]));

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready[1]),
    .A(a_in), .B(b_in), .CIN(cin_in), .SUB(sub_in),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready),
    .S(s_out[1]), .COUT(cout_out[1]), .OVF(ovf_out[1]));

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready[2]),
    .A(a_in), .B(b_in), .CIN(cin_in), .SUB(sub_in),
    .OUT_VALID(out_valid[2]), .OUT_READY(out_ready),
    .S(s_out[2]), .COUT(cout_out[2]), .OVF(ovf_out[2]));

  function automatic int n_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic; result packed as {s[7:0], cout, ovf}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    int ua, ub, full, sr;
    logic [7:0] s;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    if (sub) begin
      full = ua - ub + 256;
      sr   = int'($signed(a)) - int'($signed(b));
    end else begin
      full = ua + ub + int'(cin);
      sr   = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    s = 8'(full);
    c = (full >= 256);
    o = (sr > 127) || (sr < -128);
    return {s, c, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare process for all three instances.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        expq[i].delete();
        last_res[i] = '0;
        prev_ov[i]  = 1'b0;
        prev_acc[i] = -1;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ready_and_valid[%0d]", i), 32'(in_ready[i] & out_valid[i]), 32'd0);
        if (out_valid[i]) begin
          if (expq[i].size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_result[%0d]: got OUT_VALID=1 expected no result pending", i);
          end else begin
            chk($sformatf("s[%0d]", i),    32'(s_out[i]),    32'(expq[i][0][9:2]));
            chk($sformatf("cout[%0d]", i), 32'(cout_out[i]), 32'(expq[i][0][1]));
            chk($sformatf("ovf[%0d]", i),  32'(ovf_out[i]),  32'(expq[i][0][0]));
            if (!prev_ov[i])
              chk($sformatf("latency[%0d]", i), 32'(cyc - acc_cyc[i]), 32'(n_of(i)));
            if (out_ready) last_res[i] = expq[i].pop_front();
          end
        end else if (in_ready[i]) begin
          chk($sformatf("idle_hold_s[%0d]", i),    32'(s_out[i]),    32'(last_res[i][9:2]));
          chk($sformatf("idle_hold_cout[%0d]", i), 32'(cout_out[i]), 32'(last_res[i][1]));
          chk($sformatf("idle_hold_ovf[%0d]", i),  32'(ovf_out[i]),  32'(last_res[i][0]));
        end
        prev_ov[i] = out_valid[i];
        if (!b2b) prev_acc[i] = -1;
        if (in_valid && in_ready[i]) begin
          if (b2b && prev_acc[i] >= 0)
            chk($sformatf("b2b_interval[%0d]", i), 32'(cyc + 1 - prev_acc[i]), 32'(n_of(i) + 2));
          acc_cyc[i]  = cyc + 1;
          prev_acc[i] = cyc + 1;
          expq[i].push_back(model(a_in, b_in, cin_in, sub_in));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(in_ready[0] && in_ready[1] && in_ready[2]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errs++;
      $display("FAIL wait_ready: got timeout expected all IN_READY");
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(out_valid[0] && out_valid[1] && out_valid[2]) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errs++;
      $display("FAIL wait_done: got timeout expected all OUT_VALID");
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
    wait_ready();
    a_in = a; b_in = b; cin_in = cin; sub_in = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_lit(input string name, input logic [7:0] es, input logic ec, input logic eo);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_s[%0d]", name, i),    32'(s_out[i]),    32'(es));
      chk($sformatf("%s_cout[%0d]", name, i), 32'(cout_out[i]), 32'(ec));
      chk($sformatf("%s_ovf[%0d]", name, i),  32'(ovf_out[i]),  32'(eo));
    end
  endtask

  task automatic run_lit(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub,
                         input logic [7:0] es, input logic ec, input logic eo);
    chk({name, "_model"}, 32'(model(a, b, cin, sub)), 32'({es, ec, eo}));
    start_op(a, b, cin, sub);
    wait_done();
    check_lit(name, es, ec, eo);
    release_res();
  endtask

  task automatic check_reset_vals(input string name);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_in_ready[%0d]", name, i),  32'(in_ready[i]),  32'd1);
      chk($sformatf("%s_out_valid[%0d]", name, i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("%s_s[%0d]", name, i),         32'(s_out[i]),     32'd0);
      chk($sformatf("%s_cout[%0d]", name, i),      32'(cout_out[i]),  32'd0);
      chk($sformatf("%s_ovf[%0d]", name, i),       32'(ovf_out[i]),   32'd0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_lit("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    run_lit("add_ff_01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    run_lit("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_lit("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Backpressure: result held while new operands are offered.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      a_in = 8'($urandom); b_in = 8'($urandom);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    check_lit("bp_hold", 8'h96, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_no_capture[%0d]", i), 32'(expq[i].size()), 32'd1);
    in_valid = 1'b0;
    release_res();
    run_lit("after_bp", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    // Reset in the middle of an operation.
    start_op(8'h77, 8'h11, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    run_lit("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // Back-to-back with both handshakes held high.
    b2b = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      a_in = 8'($urandom); b_in = 8'($urandom);
      cin_in = 1'($urandom); sub_in = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    b2b = 1'b0;
    out_ready = 1'b0;

    // Randomised traffic with random stalls on both sides.
    for (int k = 0; k < 16000; k++) begin
      a_in = 8'($urandom); b_in = 8'($urandom);
      cin_in = 1'($urandom); sub_in = 1'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("drained[%0d]", i), 32'(expq[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
